sponge_absorb: RTL and testbench
================================

# sponge_absorb

Keccak sponge absorber that sits directly upstream of the state-array and permutation stage. It accepts a message as a stream of 64-bit little-endian words and XORs them into the rate lanes of a 1600-bit state register. It applies SHA-3/SHAKE pad10*1 with a domain-separation byte, and hands each full rate block to the permutation through a start/done handshake. When the last block has been permuted, it holds the final state for the squeeze side.

## Interface
- RATE_WORDS, 21, rate in 64-bit lanes (21 = SHAKE128, 17 = SHAKE256); legal 1..24
- DS_BYTE, 8'h1F, domain-separation byte (8'h06 for SHA3)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  message word valid
- in_ready  out  1  absorber can accept a word
- in_data  in  64  message word; byte i at bits [8i+7:8i]
- in_last  in  1  word is the final message word
- in_bytes  in  4  valid bytes in a last word, 0..8; ignored when in_last=0
- perm_start  out  1  one-cycle pulse requesting a permutation
- state_out  out  1600  current state; lane (x,y) at bits [64(5y+x)+63 : 64(5y+x)]
- perm_done  in  1  permutation finished; state_in valid
- state_in  in  1600  permuted state, same bit mapping
- out_valid  out  1  final absorbed state available on state_out
- out_ready  in  1  consumer has taken final state

## Operation
- Lane index L = 5y+x. Message words fill lanes 0..RATE_WORDS-1 in order. Word counter cnt runs 0..RATE_WORDS-1.
- FSM states: ABSORB, PAD, PERM, DONE.
- ABSORB: in_ready=1. A transfer occurs when in_valid=1 and in_ready=1. The word is XORed into lane cnt.
  - For a last word, bytes ≥ in_bytes are masked to zero before the XOR.
  - Non-last word, cnt<RATE_WORDS-1: cnt++.
  - Non-last word, cnt=RATE_WORDS-1: cnt=0, go to PERM.
  - Last word, in_bytes<8: also XOR DS_BYTE into byte in_bytes of lane cnt, and 8'h80 into byte 7 of lane RATE_WORDS-1. Both XORs land in the same register update. If they hit the same byte, the result is DS_BYTE^8'h80. Set final=1, cnt=0, go to PERM.
  - Last word, in_bytes=8, cnt<RATE_WORDS-1: cnt++, go to PAD.
  - Last word, in_bytes=8, cnt=RATE_WORDS-1: set pad_pending=1, cnt=0, go to PERM.
- PAD: in_ready=0. Apply the same padding at byte 0 of lane cnt. Set final=1, cnt=0, go to PERM. Takes one cycle.
- PERM: in_ready=0. perm_start pulses high in the first PERM cycle only. state_out holds steady until perm_done.
  - When perm_done=1: load state_in into the state register.
  - Next state: DONE if final=1; otherwise PAD (clearing pad_pending) if pad_pending=1; otherwise ABSORB.
- DONE: out_valid=1, in_ready=0, state held. When out_ready=1: zero the state, clear final, go to ABSORB.
- Capacity lanes (L ≥ RATE_WORDS) are never written except from state_in.
- perm_done outside PERM, and in the same cycle as perm_start, is ignored.
- Reset values: FSM=ABSORB, state=0, cnt=0, final=0, pad_pending=0, perm_start=0, out_valid=0, in_ready=1. No transfer is accepted while reset is low.
- Reset mid-operation (any state) returns everything to the reset values immediately. A permutation in flight is abandoned.

## Timing
- Block-completing word accepted at edge N → PERM entered at edge N, perm_start high in cycle N+1 only.
- Padding case (in_bytes=8, not at the block end): PAD in cycle N+1, perm_start high in cycle N+2.
- perm_done sampled at edge M → state register updated at edge M. The next state (ABSORB/PAD/DONE) is active from cycle M+1.
- out_valid goes high the cycle after the final perm_done and stays high until an out_ready handshake.
- Throughput: one word per cycle in ABSORB. No word is accepted from block completion until perm_done is returned.

## Structure
- keccak_pkg holds:
  - STATE_W=1600, LANE_W=64
  - lane-offset function lane_lsb(x,y)=64(5y+x)
  - the absorb FSM enum
  - DS constants for SHA3 and SHAKE
- One combinational sub-module, keccak_pad_lane, takes data, in_bytes, the pad enable and the final-lane flag, and returns the masked and padded 64-bit lane.

## Test plan
- Empty SHAKE128 message: in_last=1, in_bytes=0 at cnt 0 → lane0=64'h1F, lane20=64'h8000000000000000, all other lanes 0; perm_start one pulse.
- 3-byte message 0xABCDEF (in_data=64'h0000000000ABCDEF, in_bytes=3) → lane0=64'h000000001FABCDEF, lane20 bit 63 set.
- 21 full words, last with in_bytes=8 → PERM with pad_pending. After perm_done returns a known state S, PAD XORs 0x1F into lane0 and 0x80 into byte 7 of lane20 of S, then a second perm_start.
- RATE_WORDS=17, DS_BYTE=8'h06, last word at cnt 16 with in_bytes=7 → byte 7 of lane16 = 8'h86.
- perm_done held off 10 cycles with in_valid=1 → in_ready=0 throughout and no state change. A spurious perm_done in DONE is ignored; out_ready clears the state to 0.
- reset pulsed low during PERM → all outputs return to reset values asynchronously; a fresh message afterwards absorbs correctly.

Source files
------------

// File: rtl/keccak_pkg.sv
// Shared Keccak constants, lane addressing and the absorb FSM encoding.
package keccak_pkg;

    localparam int STATE_W = 1600;
    localparam int LANE_W  = 64;

    localparam logic [7:0] DS_SHA3  = 8'h06;
    localparam logic [7:0] DS_SHAKE = 8'h1F;
    localparam logic [7:0] PAD_LAST = 8'h80;

    typedef enum logic [1:0] {
        ST_ABSORB,
        ST_PAD,
        ST_PERM,
        ST_DONE
    } absorb_state_e;

    function automatic int lane_lsb(input int x, input int y);
        return LANE_W * (5 * y + x);
    endfunction

endpackage

// File: rtl/keccak_pad_lane.sv
// Masks a message lane to its valid bytes and applies pad10*1 bytes to it.
module keccak_pad_lane
    import keccak_pkg::*;
#(
    parameter logic [7:0] DS_BYTE = DS_SHAKE
) (
    input  logic [63:0] data,
    input  logic [3:0]  nbytes,
    input  logic        pad_en,
    input  logic        final_lane,
    output logic [63:0] lane
);

    always_comb begin
        lane = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                lane[8*i +: 8] = data[8*i +: 8];
            end
            if (pad_en && (4'(i) == nbytes)) begin
                lane[8*i +: 8] = lane[8*i +: 8] ^ DS_BYTE;
            end
        end
        // Applied after the DS byte so a shared byte 7 ends up as DS_BYTE ^ 0x80.
        if (pad_en && final_lane) begin
            lane[63:56] = lane[63:56] ^ PAD_LAST;
        end
    end

endmodule

// File: rtl/sponge_absorb.sv
// Keccak sponge absorber: XORs message words into the rate lanes, pads,
// and hands each rate block to the permutation via perm_start/perm_done.
module sponge_absorb
    import keccak_pkg::*;
#(
    parameter int         RATE_WORDS = 21,
    parameter logic [7:0] DS_BYTE    = DS_SHAKE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          in_last,
    input  logic [3:0]    in_bytes,
    output logic          perm_start,
    output logic [1599:0] state_out,
    input  logic          perm_done,
    input  logic [1599:0] state_in,
    output logic          out_valid,
    input  logic          out_ready
);

    localparam int             CNT_W         = 5;
    localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(RATE_WORDS - 1);
    localparam int             LAST_LANE_LSB = lane_lsb((RATE_WORDS - 1) % 5, (RATE_WORDS - 1) / 5);

    absorb_state_e        fsm_q, fsm_d;
    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 final_q, final_d;
    logic                 pad_pending_q, pad_pending_d;
    logic                 perm_start_q, perm_start_d;

    logic [63:0]          pl_data;
    logic [3:0]           pl_nbytes;
    logic                 pl_pad_en;
    logic                 pl_final_lane;
    logic [63:0]          pl_lane;

    assign in_ready      = (fsm_q == ST_ABSORB);
    assign out_valid     = (fsm_q == ST_DONE);
    assign perm_start    = perm_start_q;
    assign state_out     = state_q;
    assign pl_final_lane = (cnt_q == LAST_CNT);

    // In PAD the lane carries no message bytes, only the padding at byte 0.
    always_comb begin
        pl_data   = in_data;
        pl_nbytes = in_last ? in_bytes : 4'd8;
        pl_pad_en = in_last && (in_bytes < 4'd8);
        if (fsm_q == ST_PAD) begin
            pl_data   = '0;
            pl_nbytes = '0;
            pl_pad_en = 1'b1;
        end
    end

    keccak_pad_lane #(
        .DS_BYTE (DS_BYTE)
    ) u_pad_lane (
        .data       (pl_data),
        .nbytes     (pl_nbytes),
        .pad_en     (pl_pad_en),
        .final_lane (pl_final_lane),
        .lane       (pl_lane)
    );

    always_comb begin
        fsm_d         = fsm_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        final_d       = final_q;
        pad_pending_d = pad_pending_q;
        perm_start_d  = 1'b0;

        case (fsm_q)
            ST_ABSORB: begin
                if (in_valid) begin
                    state_d[LANE_W*int'(cnt_q) +: LANE_W] = state_q[LANE_W*int'(cnt_q) +: LANE_W] ^ pl_lane;
                    if (pl_pad_en && !pl_final_lane) begin
                        state_d[LAST_LANE_LSB+56 +: 8] = state_q[LAST_LANE_LSB+56 +: 8] ^ PAD_LAST;
                    end
                    if (pl_pad_en) begin
                        final_d      = 1'b1;
                        cnt_d        = '0;
                        fsm_d        = ST_PERM;
                        perm_start_d = 1'b1;
                    end else if (cnt_q == LAST_CNT) begin
                        // A full last word at the block end leaves the padding for an extra block.
                        pad_pending_d = in_last;
                        cnt_d         = '0;
                        fsm_d         = ST_PERM;
                        perm_start_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (in_last) begin
                            fsm_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                state_d[LANE_W*int'(cnt_q) +: LANE_W] = state_q[LANE_W*int'(cnt_q) +: LANE_W] ^ pl_lane;
                if (!pl_final_lane) begin
                    state_d[LAST_LANE_LSB+56 +: 8] = state_q[LAST_LANE_LSB+56 +: 8] ^ PAD_LAST;
                end
                final_d      = 1'b1;
                cnt_d        = '0;
                fsm_d        = ST_PERM;
                perm_start_d = 1'b1;
            end
            ST_PERM: begin
                // A done coincident with the start pulse belongs to no request of ours.
                if (perm_done && !perm_start_q) begin
                    state_d = state_in;
                    if (final_q) begin
                        fsm_d = ST_DONE;
                    end else if (pad_pending_q) begin
                        pad_pending_d = 1'b0;
                        fsm_d         = ST_PAD;
                    end else begin
                        fsm_d = ST_ABSORB;
                    end
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = '0;
                    final_d = 1'b0;
                    fsm_d   = ST_ABSORB;
                end
            end
            default: fsm_d = ST_ABSORB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q         <= ST_ABSORB;
            state_q       <= '0;
            cnt_q         <= '0;
            final_q       <= 1'b0;
            pad_pending_q <= 1'b0;
            perm_start_q  <= 1'b0;
        end else begin
            fsm_q         <= fsm_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            final_q       <= final_d;
            pad_pending_q <= pad_pending_d;
            perm_start_q  <= perm_start_d;
        end
    end

endmodule

// File: tb/tb_sponge_absorb.sv
// Bench for sponge_absorb: directed corner cases plus random messages checked
// against a byte-level pad10*1 sponge model with a stand-in permutation.
module tb_sponge_absorb;
    import keccak_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          sel;
    logic          in_valid, in_last, perm_done, out_ready;
    logic [63:0]   in_data;
    logic [3:0]    in_bytes;
    logic [1599:0] state_in;

    logic          a_in_ready, a_perm_start, a_out_valid;
    logic [1599:0] a_state_out;
    logic          b_in_ready, b_perm_start, b_out_valid;
    logic [1599:0] b_state_out;

    logic          in_ready_m, perm_start_m, out_valid_m;
    logic [1599:0] state_out_m;

    int checks = 0;
    int errors = 0;
    logic          agent_en;
    int            perm_idx;
    logic [1599:0] first_pre;
    logic [1599:0] exp_pre[$];
    logic [1599:0] exp_final;
    logic [7:0]    msg[$];

    always #5 clk = ~clk;

    assign in_ready_m   = sel ? b_in_ready   : a_in_ready;
    assign perm_start_m = sel ? b_perm_start : a_perm_start;
    assign out_valid_m  = sel ? b_out_valid  : a_out_valid;
    assign state_out_m  = sel ? b_state_out  : a_state_out;

    sponge_absorb #(.RATE_WORDS(21), .DS_BYTE(DS_SHAKE)) dut_a (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && !sel), .in_ready(a_in_ready),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .perm_start(a_perm_start), .state_out(a_state_out),
        .perm_done(perm_done && !sel), .state_in(state_in),
        .out_valid(a_out_valid), .out_ready(out_ready && !sel)
    );

    sponge_absorb #(.RATE_WORDS(17), .DS_BYTE(DS_SHA3)) dut_b (
        .clk(clk), .reset(reset),
        .in_valid(in_valid && sel), .in_ready(b_in_ready),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .perm_start(b_perm_start), .state_out(b_state_out),
        .perm_done(perm_done && sel), .state_in(state_in),
        .out_valid(b_out_valid), .out_ready(out_ready && sel)
    );

    function automatic int rate_words();
        return sel ? 17 : 21;
    endfunction

    function automatic logic [7:0] ds_byte();
        return sel ? 8'h06 : 8'h1F;
    endfunction

    // Stand-in permutation: lane shuffle, per-lane rotate, per-lane constant.
    function automatic logic [1599:0] perm_f(input logic [1599:0] s);
        logic [1599:0] r;
        logic [63:0]   l;
        for (int i = 0; i < 25; i++) begin
            l = s[64*((i+7)%25) +: 64];
            r[64*i +: 64] = ((l << (i+1)) | (l >> (63-i))) ^ (64'hC0FFEE0000000000 | 64'(i));
        end
        return r;
    endfunction

    function automatic logic [1599:0] rand_state();
        logic [1599:0] r;
        for (int i = 0; i < 50; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
        int bad;
        checks++;
        assert (obs === exp) else begin
            errors++;
            bad = 0;
            for (int i = 24; i >= 0; i--)
                if (obs[64*i +: 64] !== exp[64*i +: 64]) bad = i;
            $error("FAIL %s lane %0d observed=%h expected=%h", tag, bad, obs[64*bad +: 64], exp[64*bad +: 64]);
        end
    endtask

    // Sponge model on the byte stream: pad10*1 to a whole number of rate blocks.
    task automatic build_model();
        int rb, p, total;
        logic [7:0]    blk[];
        logic [1599:0] st;
        rb = 8 * rate_words();
        p = msg.size();
        total = (p / rb + 1) * rb;
        blk = new[total];
        for (int j = 0; j < total; j++) blk[j] = (j < p) ? msg[j] : 8'h00;
        blk[p] = blk[p] ^ ds_byte();
        blk[total-1] = blk[total-1] ^ 8'h80;
        st = '0;
        exp_pre.delete();
        for (int b = 0; b < total / rb; b++) begin
            for (int j = 0; j < rb; j++) st[8*j +: 8] = st[8*j +: 8] ^ blk[b*rb + j];
            exp_pre.push_back(st);
            st = perm_f(st);
        end
        exp_final = st;
    endtask

    // Called and returns at a negedge; the transfer happens on the posedge in between.
    task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        n = 0;
        while (!in_ready_m && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("in_ready_timeout", 64'(in_ready_m), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg();
        int p, nw;
        logic [63:0] w;
        logic [3:0]  nb;
        p = msg.size();
        nw = (p == 0) ? 1 : (p + 7) / 8;
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            for (int k = 0; k < 8; k++)
                if (8*i + k < p) w[8*k +: 8] = msg[8*i + k];
            nb = (i == nw - 1) ? 4'(p - 8*(nw-1)) : 4'($urandom_range(0, 15));
            send_word(w, i == nw - 1, nb);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!out_valid_m && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid", 64'(out_valid_m), 64'd1);
        chk_state("final_state", state_out_m, exp_final);
        chk("perms_outstanding", 64'(exp_pre.size()), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_state("state_cleared", state_out_m, '0);
        chk("out_valid_cleared", 64'(out_valid_m), 64'd0);
        chk("in_ready_after_done", 64'(in_ready_m), 64'd1);
    endtask

    task automatic run_random(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
        build_model();
        perm_idx = 0;
        send_msg();
        wait_done();
    endtask

    // Permutation responder: checks each block as presented, then returns perm_f of it.
    always begin
        logic [1599:0] snap;
        int lat;
        @(negedge clk);
        if (agent_en && perm_start_m === 1'b1) begin
            snap = state_out_m;
            if (perm_idx == 0) first_pre = snap;
            perm_idx++;
            chk("perm_expected", 64'(exp_pre.size() != 0), 64'd1);
            if (exp_pre.size() != 0) chk_state("pre_perm_state", snap, exp_pre.pop_front());
            lat = $urandom_range(1, 4);
            repeat (lat) @(negedge clk);
            chk_state("state_hold_in_perm", state_out_m, snap);
            state_in  = perm_f(snap);
            perm_done = 1'b1;
            @(negedge clk);
            perm_done = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1599:0] s, e;
        logic [1599:0] held;
        int lens[12] = '{0, 3, 7, 8, 160, 167, 168, 169, 336, 0, 0, 0};

        sel = 1'b0; agent_en = 1'b0; perm_idx = 0;
        in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_bytes = '0;
        perm_done = 1'b0; out_ready = 1'b0; state_in = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready_m), 64'd1);
        chk("reset_perm_start", 64'(perm_start_m), 64'd0);
        chk("reset_out_valid", 64'(out_valid_m), 64'd0);
        chk_state("reset_state", state_out_m, '0);
        reset = 1'b1;
        @(negedge clk);

        // Empty message
        send_word(64'hDEADBEEFCAFEF00D, 1'b1, 4'd0);
        chk("empty_perm_start", 64'(perm_start_m), 64'd1);
        e = '0;
        e[7:0] = 8'h1F;
        e[64*20+56 +: 8] = 8'h80;
        chk_state("empty_msg_state", state_out_m, e);
        @(negedge clk);
        chk("perm_start_one_pulse", 64'(perm_start_m), 64'd0);
        // Permutation held off with a word pending
        in_valid = 1'b1; in_data = {$urandom, $urandom}; in_last = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("holdoff_in_ready", 64'(in_ready_m), 64'd0);
            chk_state("holdoff_state", state_out_m, e);
        end
        in_valid = 1'b0;
        s = rand_state();
        state_in = s; perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        chk("done_out_valid", 64'(out_valid_m), 64'd1);
        chk_state("done_state", state_out_m, s);
        state_in = ~s; perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        @(negedge clk);
        chk_state("spurious_done_ignored", state_out_m, s);
        chk("spurious_out_valid", 64'(out_valid_m), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk_state("out_ready_clears", state_out_m, '0);
        chk("out_ready_in_ready", 64'(in_ready_m), 64'd1);

        // 3-byte message with junk above the valid bytes; done coincident with start
        send_word(64'h5A5A5A5A5AABCDEF, 1'b1, 4'd3);
        chk("three_byte_perm_start", 64'(perm_start_m), 64'd1);
        chk("three_byte_lane0", state_out_m[63:0], 64'h000000001FABCDEF);
        chk("three_byte_lane20", state_out_m[64*20 +: 64], 64'h8000000000000000);
        held = state_out_m;
        s = rand_state();
        state_in = s; perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        chk("done_with_start_ignored", 64'(out_valid_m), 64'd0);
        chk_state("done_with_start_state", state_out_m, held);
        perm_done = 1'b1;
        @(negedge clk);
        perm_done = 1'b0;
        chk_state("three_byte_permuted", state_out_m, s);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Random messages covering PAD, pad_pending and shared-byte padding
        agent_en = 1'b1;
        for (int i = 9; i < 12; i++) lens[i] = $urandom_range(1, 400);
        for (int i = 0; i < 12; i++) run_random(lens[i]);

        // Reset while a permutation is outstanding
        agent_en = 1'b0;
        for (int i = 0; i < 21; i++) send_word({$urandom, $urandom}, 1'b0, 4'($urandom_range(0, 15)));
        chk("reset_test_perm_start", 64'(perm_start_m), 64'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_in_ready", 64'(in_ready_m), 64'd1);
        chk("async_reset_perm_start", 64'(perm_start_m), 64'd0);
        chk("async_reset_out_valid", 64'(out_valid_m), 64'd0);
        chk_state("async_reset_state", state_out_m, '0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        agent_en = 1'b1;
        run_random(50);

        // SHA3-256 instance: last word at lane 16 with 7 bytes shares byte 7
        sel = 1'b1;
        @(negedge clk);
        run_random(135);
        chk("sha3_shared_pad_byte", 64'(first_pre[64*16+56 +: 8]), 64'h86);
        run_random(136);
        run_random($urandom_range(1, 300));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
